// File: rtl/switch_debounce.sv
// switch_debounce: two-flop synchronizer per switch bit followed by a
// per-nibble debouncer. A group's stable value is replaced only after the
// synchronized group value has held a new value for DEBOUNCE_CYCLES edges;
// changed[g] pulses for the one cycle in which stable[g] updates.
// Optional build macro SWITCH_CHANGE_COUNT_EN adds an 8-bit wrapping count
// of accepted group updates (change_count), lagging changed by one cycle.
module switch_debounce #(
    parameter  int WIDTH           = 16,
    parameter  int GROUP           = 4,
    parameter  int DEBOUNCE_CYCLES = 100000,
    localparam int NGROUPS         = WIDTH / GROUP
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   switch,
    output logic [WIDTH-1:0]   stable,
    output logic [NGROUPS-1:0] changed
`ifdef SWITCH_CHANGE_COUNT_EN
    ,
    output logic [7:0]         change_count
`endif
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]   sync1;
    logic [WIDTH-1:0]   sync2;
    logic [GROUP-1:0]   cand   [NGROUPS];
    logic [CW-1:0]      cnt    [NGROUPS];

    logic [GROUP-1:0]   cand_n [NGROUPS];
    logic [CW-1:0]      cnt_n  [NGROUPS];
    logic [WIDTH-1:0]   stable_n;
    logic [NGROUPS-1:0] changed_n;
    logic [GROUP-1:0]   s;

    // Two-stage synchronizer, no logic between the stages
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= switch;
            sync2 <= sync1;
        end
    end

    // Per-group candidate tracking and acceptance decision
    always_comb begin
        cand_n    = cand;
        cnt_n     = cnt;
        stable_n  = stable;
        changed_n = '0;
        s         = '0;
        for (int unsigned g = 0; g < NGROUPS; g++) begin
            s = sync2[g*GROUP +: GROUP];
            if (s == stable[g*GROUP +: GROUP]) begin
                cnt_n[g]  = '0;
                cand_n[g] = s;
            end else if (s != cand[g]) begin
                cand_n[g] = s;
                cnt_n[g]  = CW'(1);
            end else if (cnt[g] == LAST) begin
                stable_n[g*GROUP +: GROUP] = s;
                cnt_n[g]                   = '0;
                changed_n[g]               = 1'b1;
            end else begin
                cnt_n[g] = cnt[g] + 1'b1;
            end
        end
    end

    // Debouncer state and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned g = 0; g < NGROUPS; g++) begin
                cand[g] <= '0;
                cnt[g]  <= '0;
            end
            stable  <= '0;
            changed <= '0;
        end else begin
            cand    <= cand_n;
            cnt     <= cnt_n;
            stable  <= stable_n;
            changed <= changed_n;
        end
    end

`ifdef SWITCH_CHANGE_COUNT_EN
    logic [7:0] inc;

    // Number of groups pulsing this cycle
    always_comb begin
        inc = '0;
        for (int unsigned g = 0; g < NGROUPS; g++) begin
            inc = inc + 8'(changed[g]);
        end
    end

    // Wrapping accumulation of accepted group updates
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            change_count <= '0;
        end else begin
            change_count <= change_count + inc;
        end
    end
`endif

endmodule
